// File: rtl/sobel_magnitude_3x3.sv
// Sobel edge-strength stage: two line buffers, 3x3 window,
// saturated |Gx|+|Gy| with border and blanking masking.
module sobel_magnitude_3x3 #(
  parameter int LINE_WIDTH = 640,
  parameter int LINE_COUNT = 480
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       blanking_in,
  input  logic       validin,
  output logic [7:0] dout,
  output logic       blanking_out,
  output logic       validout
);

  localparam int LATENCY = LINE_WIDTH + 4;
  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(LINE_COUNT);
  localparam int FW = $clog2(LATENCY);

  localparam logic [CW-1:0] COL_MAX = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(LINE_COUNT - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(LATENCY - 1);
  localparam logic [FW-1:0] CTR_GO = FW'(LINE_WIDTH + 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] fill_q, fill_d;

  logic [7:0] lb0_q [LINE_WIDTH];
  logic [7:0] lb1_q [LINE_WIDTH];
  logic [7:0] lb0_rd, lb1_rd;

  logic [2:0][2:0][7:0] win_q, win_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [RW-1:0] wr_q, wr_d;
  logic          wblk_q, wblk_d;
  logic [LINE_WIDTH:0] bsr_q, bsr_d;

  logic [10:0] gx_q, gx_d;
  logic [10:0] gy_q, gy_d;
  logic        gbord_q, gbord_d;
  logic        gblk_q, gblk_d;

  logic [7:0] dout_q, dout_d;
  logic       bout_q, bout_d;
  logic       vout_q, vout_d;

  logic [10:0] gx_pos, gx_neg, gy_pos, gy_neg;
  logic [10:0] ax, ay, mag;
  logic [7:0]  sat;

  assign lb0_rd = lb0_q[col_q];
  assign lb1_rd = lb1_q[col_q];

  // Line buffers: circular, addressed by the input column.
  always_ff @(posedge clock) begin
    if (validin) begin
      lb0_q[col_q] <= din;
      lb1_q[col_q] <= lb0_rd;
    end
  end

  // Gradient kernels on the current window.
  always_comb begin
    gx_pos = {3'b0, win_q[0][2]} + {2'b0, win_q[1][2], 1'b0}
           + {3'b0, win_q[2][2]};
    gx_neg = {3'b0, win_q[0][0]} + {2'b0, win_q[1][0], 1'b0}
           + {3'b0, win_q[2][0]};
    gy_pos = {3'b0, win_q[2][0]} + {2'b0, win_q[2][1], 1'b0}
           + {3'b0, win_q[2][2]};
    gy_neg = {3'b0, win_q[0][0]} + {2'b0, win_q[0][1], 1'b0}
           + {3'b0, win_q[0][2]};
  end

  // Absolute values, sum and saturation.
  always_comb begin
    ax  = gx_q[10] ? (~gx_q + 11'd1) : gx_q;
    ay  = gy_q[10] ? (~gy_q + 11'd1) : gy_q;
    mag = ax + ay;
    sat = (|mag[10:8]) ? 8'hFF : mag[7:0];
  end

  // Next state: everything advances only on accepted cycles.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    fill_d  = fill_q;
    win_d   = win_q;
    wc_d    = wc_q;
    wr_d    = wr_q;
    wblk_d  = wblk_q;
    bsr_d   = bsr_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    gbord_d = gbord_q;
    gblk_d  = gblk_q;
    dout_d  = dout_q;
    bout_d  = bout_q;
    vout_d  = validin && (fill_q == FILL_MAX);
    if (validin) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (fill_q != FILL_MAX) fill_d = fill_q + FW'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = din;
      if (fill_q > CTR_GO) begin
        if (wc_q == COL_MAX) begin
          wc_d = '0;
          wr_d = (wr_q == ROW_MAX) ? '0 : wr_q + RW'(1);
        end else begin
          wc_d = wc_q + CW'(1);
        end
      end
      bsr_d   = {bsr_q[LINE_WIDTH-1:0], blanking_in};
      wblk_d  = bsr_q[LINE_WIDTH];
      gx_d    = gx_pos - gx_neg;
      gy_d    = gy_pos - gy_neg;
      gbord_d = (wc_q == '0) || (wc_q == COL_MAX)
             || (wr_q == '0) || (wr_q == ROW_MAX);
      gblk_d  = wblk_q;
      dout_d  = (gbord_q || gblk_q) ? 8'd0 : sat;
      bout_d  = gblk_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      fill_q  <= '0;
      win_q   <= '0;
      wc_q    <= '0;
      wr_q    <= '0;
      wblk_q  <= 1'b0;
      bsr_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      gbord_q <= 1'b1;
      gblk_q  <= 1'b0;
      dout_q  <= '0;
      bout_q  <= 1'b0;
      vout_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      fill_q  <= fill_d;
      win_q   <= win_d;
      wc_q    <= wc_d;
      wr_q    <= wr_d;
      wblk_q  <= wblk_d;
      bsr_q   <= bsr_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      gbord_q <= gbord_d;
      gblk_q  <= gblk_d;
      dout_q  <= dout_d;
      bout_q  <= bout_d;
      vout_q  <= vout_d;
    end
  end

  assign dout         = dout_q;
  assign blanking_out = bout_q;
  assign validout     = vout_q;

endmodule
